// File: rtl/prog_loader_if.sv
// Byte-stream input and CPU programming port of the program loader.
interface prog_loader_if #(
    parameter int ADRS_W = 11,
    parameter int DATA_W = 32
);
    logic              load_req;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] w_instruction;
    logic              w_enable;
    logic [ADRS_W-1:0] w_adrs;
    logic              cpu_en;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output load_req, in_byte, in_valid,
        input  in_ready, w_instruction, w_enable, w_adrs,
        input  cpu_en, busy, done, err
    );

    modport slave (
        input  load_req, in_byte, in_valid,
        output in_ready, w_instruction, w_enable, w_adrs,
        output cpu_en, busy, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-serial loader: header, data words, XOR checksum,
// writes CPU memory and releases the CPU on a clean frame.
module prog_loader #(
    parameter int ADRS_W = 11,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         resetn,
    prog_loader_if.slave bus
);
    localparam int BPW   = DATA_W / 8;
    localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int HDR_N = 2 * CNT_W / 8;
    localparam int HC_W  = (HDR_N > 1) ? $clog2(HDR_N) : 1;
    localparam int MAX_W = (CNT_W > ADRS_W) ? CNT_W : ADRS_W;
    localparam int SUM_W = MAX_W + 1;
    localparam logic [SUM_W-1:0] DEPTH = SUM_W'(1) << ADRS_W;

    typedef enum logic [2:0] {
        IDLE, HDR, DATA, CHK, RUN, ERR
    } state_t;

    state_t              state;
    logic [HC_W-1:0]     hdr_idx;
    logic [BC_W-1:0]     byte_idx;
    logic [CNT_W-1:0]    words_left;
    logic [ADRS_W-1:0]   adrs;
    logic [7:0]          csum;
    logic [2*CNT_W-1:0]  hdr_sh;
    logic [DATA_W-1:0]   word_sh;

    logic                ready;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_en;
    logic [ADRS_W-1:0]   wr_adrs;
    logic                run;
    logic                active;
    logic                fin;
    logic                fault;

    logic                xfer;
    logic                last_hdr;
    logic                last_byte;
    logic [2*CNT_W-1:0]  hdr_next;
    logic [DATA_W-1:0]   word_next;
    logic [SUM_W-1:0]    start_v;
    logic [SUM_W-1:0]    count_v;
    logic                hdr_bad;

    assign bus.in_ready      = ready;
    assign bus.w_instruction = wr_data;
    assign bus.w_enable      = wr_en;
    assign bus.w_adrs        = wr_adrs;
    assign bus.cpu_en        = run;
    assign bus.busy          = active;
    assign bus.done          = fin;
    assign bus.err           = fault;

    assign xfer      = bus.in_valid & ready;
    assign last_hdr  = hdr_idx == HC_W'(HDR_N - 1);
    assign last_byte = byte_idx == BC_W'(BPW - 1);

    // Header must fit entirely inside memory; no wrap-around.
    always_comb begin
        hdr_next  = (2*CNT_W)'({hdr_sh, bus.in_byte});
        word_next = DATA_W'({word_sh, bus.in_byte});
        start_v   = SUM_W'(hdr_next[2*CNT_W-1:CNT_W]);
        count_v   = SUM_W'(hdr_next[CNT_W-1:0]);
        hdr_bad   = (count_v == '0) || (start_v >= DEPTH)
                 || (start_v + count_v > DEPTH);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            hdr_idx    <= '0;
            byte_idx   <= '0;
            words_left <= '0;
            adrs       <= '0;
            csum       <= '0;
            hdr_sh     <= '0;
            word_sh    <= '0;
            ready      <= 1'b0;
            wr_data    <= '0;
            wr_en      <= 1'b0;
            wr_adrs    <= '0;
            run        <= 1'b0;
            active     <= 1'b0;
            fin        <= 1'b0;
            fault      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            fin   <= 1'b0;
            if (bus.load_req) begin
                state    <= HDR;
                run      <= 1'b0;
                fault    <= 1'b0;
                ready    <= 1'b1;
                active   <= 1'b1;
                hdr_idx  <= '0;
                byte_idx <= '0;
                csum     <= '0;
                hdr_sh   <= '0;
                word_sh  <= '0;
            end else if (xfer) begin
                unique case (state)
                    HDR: begin
                        csum    <= csum ^ bus.in_byte;
                        hdr_sh  <= hdr_next;
                        hdr_idx <= hdr_idx + 1'b1;
                        if (last_hdr) begin
                            hdr_idx <= '0;
                            if (hdr_bad) begin
                                state  <= ERR;
                                fault  <= 1'b1;
                                ready  <= 1'b0;
                                active <= 1'b0;
                            end else begin
                                state      <= DATA;
                                adrs       <= start_v[ADRS_W-1:0];
                                words_left <= hdr_next[CNT_W-1:0];
                            end
                        end
                    end
                    DATA: begin
                        csum     <= csum ^ bus.in_byte;
                        word_sh  <= word_next;
                        byte_idx <= byte_idx + 1'b1;
                        if (last_byte) begin
                            byte_idx   <= '0;
                            wr_en      <= 1'b1;
                            wr_adrs    <= adrs;
                            wr_data    <= word_next;
                            adrs       <= adrs + 1'b1;
                            words_left <= words_left - 1'b1;
                            if (words_left == CNT_W'(1)) begin
                                state <= CHK;
                            end
                        end
                    end
                    CHK: begin
                        ready  <= 1'b0;
                        active <= 1'b0;
                        if (bus.in_byte == csum) begin
                            state <= RUN;
                            run   <= 1'b1;
                            fin   <= 1'b1;
                        end else begin
                            state <= ERR;
                            fault <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed frames plus random
// frames checked against a frame-level reference model.
module tb_prog_loader;
    localparam int ADRS_W = 11;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 2048;

    typedef struct {
        logic [ADRS_W-1:0] adrs;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    typedef struct {
        bit ok;
        int cyc;
    } res_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    wr_t  wr_q[$];
    res_t res_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prog_loader_if #(.ADRS_W(ADRS_W), .DATA_W(DATA_W)) bus ();

    prog_loader #(
        .ADRS_W(ADRS_W),
        .DATA_W(DATA_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Monitor: pops expected writes/outcomes whenever the DUT shows one.
    initial begin : monitor
        logic err_q;
        logic done_q;
        logic run_q;
        wr_t  e;
        res_t r;
        err_q  = 1'b0;
        done_q = 1'b0;
        run_q  = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.w_enable === 1'b1) begin
                check("wr_cpu_en_low", bus.cpu_en, 0);
                if (wr_q.size() == 0) begin
                    fail("wr_unexpected");
                end else begin
                    e = wr_q.pop_front();
                    check("wr_adrs", bus.w_adrs, e.adrs);
                    check("wr_data", bus.w_instruction, e.data);
                    check("wr_cycle", cyc, e.cyc);
                end
            end
            if (bus.done === 1'b1) begin
                check("done_one_cycle", done_q, 0);
                if (res_q.size() == 0) begin
                    fail("done_unexpected");
                end else begin
                    r = res_q.pop_front();
                    check("done_ok", 1'b1, r.ok);
                    check("done_cycle", cyc, r.cyc);
                    check("done_cpu_en", bus.cpu_en, 1);
                    check("done_err", bus.err, 0);
                end
            end
            if (bus.err === 1'b1 && err_q !== 1'b1) begin
                if (res_q.size() == 0) begin
                    fail("err_unexpected");
                end else begin
                    r = res_q.pop_front();
                    check("err_ok", 1'b0, r.ok);
                    check("err_cycle", cyc, r.cyc);
                    check("err_cpu_en", bus.cpu_en, 0);
                end
            end
            if (bus.cpu_en === 1'b1 && run_q !== 1'b1) begin
                check("cpu_en_rise_done", bus.done, 1);
            end
            err_q  = bus.err;
            done_q = bus.done;
            run_q  = bus.cpu_en;
        end
    end

    task automatic pulse_load(input bit with_byte, input logic [7:0] b);
        bus.load_req = 1'b1;
        bus.in_valid = with_byte;
        bus.in_byte  = b;
        @(posedge clk);
        #1;
        bus.load_req = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, output int acc);
        check("in_ready_in_frame", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        @(posedge clk);
        #1;
        acc = cyc;
        bus.in_valid = 1'b0;
    endtask

    // Reference model: build the whole frame, derive writes and outcome.
    task automatic do_frame(input int start, input int cnt,
                            input logic [31:0] words[$],
                            input logic [7:0] bad, input bit b2b,
                            input int abort_at);
        logic [7:0] fr[$];
        logic [7:0] cs;
        bit         hdr_ok;
        int         n;
        int         acc;
        int         j;
        hdr_ok = cnt > 0 && start < DEPTH && start + cnt <= DEPTH;
        pulse_load(1'b0, 8'h00);
        fr.push_back(8'(start >> 8));
        fr.push_back(8'(start));
        fr.push_back(8'(cnt >> 8));
        fr.push_back(8'(cnt));
        if (hdr_ok) begin
            for (int i = 0; i < cnt; i++) begin
                for (int k = 3; k >= 0; k--) begin
                    fr.push_back(8'(words[i] >> (8 * k)));
                end
            end
        end
        cs = 8'h00;
        foreach (fr[i]) cs = cs ^ fr[i];
        if (hdr_ok) fr.push_back(cs ^ bad);
        n = fr.size();
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                pulse_load(1'b1, fr[i]);
                return;
            end
            if (!b2b) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send(fr[i], acc);
            if (hdr_ok && i >= 4 && i < n - 1 && (i - 4) % 4 == 3) begin
                j = (i - 4) / 4;
                wr_q.push_back('{ADRS_W'(start + j), words[j], acc});
            end
            if (i == n - 1) begin
                res_q.push_back('{hdr_ok && bad == 8'h00, acc});
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((wr_q.size() != 0 || res_q.size() != 0) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("drain_writes", wr_q.size(), 0);
        check("drain_result", res_q.size(), 0);
        wr_q.delete();
        res_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_w_enable"}, bus.w_enable, 0);
        check({tag, "_w_adrs"}, bus.w_adrs, 0);
        check({tag, "_w_instr"}, bus.w_instruction, 0);
        check({tag, "_cpu_en"}, bus.cpu_en, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_err"}, bus.err, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] ws[$];
        int          acc;
        int          kind;
        int          cnt;
        int          start;
        int          ab;
        logic [7:0]  bad;

        bus.load_req = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("idle");
        bus.in_valid = 1'b0;

        ws = {32'hE000_0000};
        do_frame(4, 1, ws, 8'h00, 1'b1, -1);
        drain();
        check("one_word_in_ready", bus.in_ready, 0);
        check("one_word_cpu_en", bus.cpu_en, 1);

        ws.delete();
        ws.push_back(32'h0000_000D);
        ws.push_back(32'h0000_000F);
        ws.push_back(32'h0000_0000);
        for (int i = 3; i < 17; i++) ws.push_back($urandom);
        do_frame(0, 17, ws, 8'h00, 1'b1, -1);
        drain();
        check("mul_cpu_en", bus.cpu_en, 1);

        pulse_load(1'b0, 8'h00);
        check("reload_cpu_en", bus.cpu_en, 0);
        check("reload_in_ready", bus.in_ready, 1);
        check("reload_busy", bus.busy, 1);

        ws = {32'hE000_0000};
        do_frame(4, 1, ws, 8'hE5, 1'b1, -1);
        drain();
        check("badsum_err", bus.err, 1);
        check("badsum_cpu_en", bus.cpu_en, 0);
        check("badsum_in_ready", bus.in_ready, 0);
        pulse_load(1'b0, 8'h00);
        check("load_clears_err", bus.err, 0);

        ws.delete();
        do_frame(12'h7FF, 2, ws, 8'h00, 1'b1, -1);
        drain();
        check("ovf_err", bus.err, 1);
        check("ovf_in_ready", bus.in_ready, 0);
        check("ovf_busy", bus.busy, 0);
        do_frame(16, 0, ws, 8'h00, 1'b1, -1);
        drain();
        check("cnt0_err", bus.err, 1);
        do_frame(2048, 1, ws, 8'h00, 1'b1, -1);
        drain();
        check("start_oob_err", bus.err, 1);

        ws = {32'h1234_5678, 32'h9ABC_DEF0};
        do_frame(2046, 2, ws, 8'h00, 1'b0, -1);
        drain();
        check("edge_fit_cpu_en", bus.cpu_en, 1);

        pulse_load(1'b0, 8'h00);
        send(8'h00, acc);
        send(8'h10, acc);
        send(8'h00, acc);
        send(8'h02, acc);
        send(8'hAB, acc);
        send(8'hCD, acc);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("after_reset");
        drain();

        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            cnt  = $urandom_range(1, 6);
            ab   = -1;
            bad  = 8'h00;
            if ($urandom_range(0, 3) == 0) start = DEPTH - cnt;
            else start = $urandom_range(0, DEPTH - cnt);
            if (kind == 0) cnt = 0;
            if (kind == 1) start = DEPTH + $urandom_range(0, 100);
            if (kind == 2) start = DEPTH - cnt + $urandom_range(1, 3);
            if (kind == 3 || kind == 4) bad = 8'($urandom_range(1, 255));
            if (kind == 5) ab = $urandom_range(0, 4 + 4 * cnt);
            ws.delete();
            for (int i = 0; i < cnt; i++) ws.push_back($urandom);
            do_frame(start, cnt, ws, bad, 1'($urandom_range(0, 1)), ab);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
